// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor computing a - b - bin one bit per clock
// through a single full-subtractor cell, with valid/ready on both sides.
module serial_sub #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  // One extra counter bit so the count never wraps before WIDTH bits are done.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             br_q, br_d;
  // Published result, updated only on the final shift so it stays put
  // between results (including while the next operation is shifting).
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  // Full-subtractor cell on the current LSBs.
  logic bit_a, bit_b, d_bit, borrow;
  logic last_bit;

  assign bit_a    = ra_q[0];
  assign bit_b    = rb_q[0];
  assign d_bit    = bit_a ^ bit_b ^ br_q;
  assign borrow   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
  assign last_bit = (cnt_q == CNT_LAST);

  // Shifted views: operands move right with zero fill, difference bit
  // enters at the MSB of the result register.
  logic [WIDTH-1:0] ra_shifted, rb_shifted, rd_shifted;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_top
        assign ra_shifted[gi] = 1'b0;
        assign rb_shifted[gi] = 1'b0;
        assign rd_shifted[gi] = d_bit;
      end else begin : g_mid
        assign ra_shifted[gi] = ra_q[gi+1];
        assign rb_shifted[gi] = rb_q[gi+1];
        assign rd_shifted[gi] = rd_q[gi+1];
      end
    end
  endgenerate

  // Next-state logic for the IDLE -> SHIFT -> DONE sequence and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ra_d    = a;
          rb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        ra_d  = ra_shifted;
        rb_d  = rb_shifted;
        rd_d  = rd_shifted;
        br_d  = borrow;
        cnt_d = cnt_q + CNT_ONE;
        if (last_bit) begin
          diff_d  = rd_shifted;
          bout_d  = borrow;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  // Handshake outputs are pure state decodes; no input reaches an output.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = ~in_ready;
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed and swept checks of serial_sub at WIDTH 1, 3 and 8.
module tb_serial_sub;

  logic clk;
  logic rst_n;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, bin1, bout1, busy1;
  logic [0:0] a1, b1, diff1;
  logic       in_valid3, in_ready3, out_valid3, out_ready3, bin3, bout3, busy3;
  logic [2:0] a3, b3, diff3;
  logic       in_valid8, in_ready8, out_valid8, out_ready8, bin8, bout8, busy8;
  logic [7:0] a8, b8, diff8;

  int n_checks;
  int n_fail;
  int acc_cnt [9];
  int res_cnt [9];

  serial_sub #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .bout(bout1), .busy(busy1)
  );

  serial_sub #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .bin(bin3), .out_valid(out_valid3), .out_ready(out_ready3),
    .diff(diff3), .bout(bout3), .busy(busy3)
  );

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_ready(input int w);
    case (w)
      1:       return 32'(in_ready1);
      8:       return 32'(in_ready8);
      default: return 32'(in_ready3);
    endcase
  endfunction

  function automatic logic [31:0] rd_valid(input int w);
    case (w)
      1:       return 32'(out_valid1);
      8:       return 32'(out_valid8);
      default: return 32'(out_valid3);
    endcase
  endfunction

  function automatic logic [31:0] rd_busy(input int w);
    case (w)
      1:       return 32'(busy1);
      8:       return 32'(busy8);
      default: return 32'(busy3);
    endcase
  endfunction

  function automatic logic [31:0] rd_diff(input int w);
    case (w)
      1:       return 32'(diff1);
      8:       return 32'(diff8);
      default: return 32'(diff3);
    endcase
  endfunction

  function automatic logic [31:0] rd_bout(input int w);
    case (w)
      1:       return 32'(bout1);
      8:       return 32'(bout8);
      default: return 32'(bout3);
    endcase
  endfunction

  task automatic drive(input int w, input logic iv, input logic [7:0] av,
                       input logic [7:0] bv, input logic bi, input logic ordy);
    case (w)
      1: begin
        in_valid1 = iv; a1 = av[0:0]; b1 = bv[0:0]; bin1 = bi; out_ready1 = ordy;
      end
      8: begin
        in_valid8 = iv; a8 = av; b8 = bv; bin8 = bi; out_ready8 = ordy;
      end
      default: begin
        in_valid3 = iv; a3 = av[2:0]; b3 = bv[2:0]; bin3 = bi; out_ready3 = ordy;
      end
    endcase
  endtask

  // One full transaction, entered and left at a negedge with the DUT idle.
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, input int stall, input bit junk,
                        input logic [31:0] exp_d, input logic [31:0] exp_b);
    int   lat;
    bit   seen;
    logic ordy;
    ordy = (stall == 0);
    check_eq("idle_ready", rd_ready(w), 1);
    drive(w, 1'b1, av, bv, bi, ordy);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 64) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check_eq("acc_busy", rd_busy(w), 1);
        check_eq("acc_ready", rd_ready(w), 0);
        if (rd_busy(w) == 1) acc_cnt[w]++;
      end
      if (rd_valid(w) == 1) begin
        seen = 1;
      end else if (junk) begin
        drive(w, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), ordy);
      end else begin
        drive(w, 1'b0, av, bv, bi, ordy);
      end
    end
    drive(w, 1'b0, av, bv, bi, ordy);
    check_eq("valid_seen", 32'(seen), 1);
    check_eq("latency", lat, w + 1);
    check_eq("rdy_valid_excl", rd_ready(w), 0);
    check_eq("diff", rd_diff(w), exp_d);
    check_eq("bout", rd_bout(w), exp_b);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (junk) drive(w, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      check_eq("stall_valid", rd_valid(w), 1);
      check_eq("stall_diff", rd_diff(w), exp_d);
      check_eq("stall_bout", rd_bout(w), exp_b);
    end
    drive(w, 1'b0, av, bv, bi, 1'b1);
    @(negedge clk);
    drive(w, 1'b0, av, bv, bi, 1'b0);
    if (seen) res_cnt[w]++;
    check_eq("post_valid", rd_valid(w), 0);
    check_eq("post_ready", rd_ready(w), 1);
    check_eq("post_diff", rd_diff(w), exp_d);
    check_eq("post_bout", rd_bout(w), exp_b);
    $display("txn w=%0d a=%0d b=%0d bin=%0d diff=%0d bout=%0d lat=%0d stall=%0d",
             w, av, bv, bi, rd_diff(w), rd_bout(w), lat, stall);
  endtask

  task automatic model_op(input int w, input int av, input int bv, input int bi, input int stall);
    int full;
    int mask;
    full = av - bv - bi;
    mask = (1 << w) - 1;
    run_op(w, 8'(av), 8'(bv), 1'(bi), stall, 1'b0, 32'(full & mask), 32'(full < 0));
  endtask

  initial begin
    int  n8;
    bit  ever_valid;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 9; i++) begin
      acc_cnt[i] = 0;
      res_cnt[i] = 0;
    end
    rst_n = 1'b0;
    drive(1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    drive(3, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    drive(8, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst_ready", rd_ready(3), 1);
    check_eq("rst_valid", rd_valid(3), 0);
    check_eq("rst_busy", rd_busy(3), 0);
    check_eq("rst_diff", rd_diff(3), 0);
    check_eq("rst_bout", rd_bout(3), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-computed results.
    run_op(3, 8'd5, 8'd2, 1'b0, 0, 1'b0, 3, 0);
    run_op(3, 8'd2, 8'd5, 1'b0, 0, 1'b0, 5, 1);
    run_op(3, 8'd0, 8'd0, 1'b1, 0, 1'b0, 7, 1);
    run_op(3, 8'd7, 8'd7, 1'b1, 0, 1'b0, 7, 1);
    run_op(3, 8'd6, 8'd1, 1'b1, 10, 1'b1, 4, 0);

    // Reset in the middle of SHIFT discards the pending result.
    drive(3, 1'b1, 8'd3, 8'd1, 1'b0, 1'b1);
    @(negedge clk);
    drive(3, 1'b0, 8'd3, 8'd1, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_ready", rd_ready(3), 1);
    check_eq("abort_valid", rd_valid(3), 0);
    check_eq("abort_busy", rd_busy(3), 0);
    check_eq("abort_diff", rd_diff(3), 0);
    check_eq("abort_bout", rd_bout(3), 0);
    ever_valid = 0;
    repeat (10) begin
      @(negedge clk);
      if (rd_valid(3) == 1) ever_valid = 1;
    end
    check_eq("abort_no_valid", 32'(ever_valid), 0);
    drive(3, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    $display("txn w=3 a=3 b=1 bin=0 aborted by reset");

    // Exhaustive sweeps at WIDTH 3 and 1, random subset at WIDTH 8.
    for (int av = 0; av < 8; av++)
      for (int bv = 0; bv < 8; bv++)
        for (int bi = 0; bi < 2; bi++)
          model_op(3, av, bv, bi, int'($urandom_range(0, 2)));
    for (int av = 0; av < 2; av++)
      for (int bv = 0; bv < 2; bv++)
        for (int bi = 0; bi < 2; bi++)
          model_op(1, av, bv, bi, int'($urandom_range(0, 2)));
    n8 = 40;
    for (int i = 0; i < n8; i++)
      model_op(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    model_op(8, 0, 255, 1, 0);
    model_op(8, 255, 0, 0, 0);

    check_eq("count3_acc_res", res_cnt[3], acc_cnt[3]);
    check_eq("count3_total", res_cnt[3], 133);
    check_eq("count1_acc_res", res_cnt[1], acc_cnt[1]);
    check_eq("count1_total", res_cnt[1], 8);
    check_eq("count8_acc_res", res_cnt[8], acc_cnt[8]);
    check_eq("count8_total", res_cnt[8], n8 + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial subtractor that computes a − b − bin one bit per clock, using a single full-subtractor cell and shift registers. It complements the combinational ripple-carry adder in the same datapath. It trades area for latency and provides the difference path the adder lacks. Operands enter through a valid/ready handshake, and the result leaves through a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 3, operand and result width in bits (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low; sampled on the rising edge of clk
- in_valid  in  1  operands a, b, bin valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- bin  in  1  borrow-in
- out_valid  out  1  diff/bout valid (high only in DONE)
- out_ready  in  1  consumer accepts result
- diff  out  WIDTH  (a − b − bin) mod 2^WIDTH
- bout  out  1  borrow-out; 1 when a < b + bin (unsigned)
- busy  out  1  high in SHIFT or DONE

## Operation
- States:
  - IDLE: in_ready=1. On in_valid at an edge: capture a→ra, b→rb, bin→br; clear bit counter cnt; go to SHIFT.
  - SHIFT: each cycle process the LSB of ra and rb:
    - d = ra[0] ^ rb[0] ^ br
    - br ← (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br)
    - ra and rb shift right by 1; d shifts into the MSB of the result register rd; cnt increments.
    - After the cycle with cnt = WIDTH−1, go to DONE.
  - DONE: out_valid=1; diff=rd, bout=br, both held stable. On out_ready at an edge, go to IDLE.
- in_valid, a, b and bin are ignored outside IDLE.
- out_ready is ignored outside DONE.
- cnt width is $clog2(WIDTH)+1 and must not wrap before WIDTH bits are processed.
- diff and bout keep their last result after the DONE→IDLE handshake, until the next result overwrites them.
- Arithmetic is unsigned modulo 2^WIDTH. bout equals bit WIDTH of the (WIDTH+1)-bit value a − b − bin.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, cnt=0, ra=rb=rd=0, br=0.
  - Reset output values: in_ready=1, out_valid=0, busy=0, diff=0, bout=0.
  - Reset has priority over all other events, including in the middle of SHIFT or DONE. A pending result is discarded and out_valid is never asserted for it.
- Latency: operands are accepted at edge E0. SHIFT edges are E1..E_WIDTH. out_valid is high in the cycle after E_WIDTH, so the first result cycle is WIDTH+1 cycles after acceptance.
- in_ready drops in the cycle after acceptance and returns in the cycle after the out_valid & out_ready edge.
- There is no back-to-back overlap. Minimum issue interval is WIDTH+2 cycles, reached when out_ready is held high.
- Backpressure: out_valid stays high and diff/bout stay constant for any number of cycles while out_ready=0.
- in_ready and out_valid are never high in the same cycle.
- busy = ~in_ready.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then a=5, b=2, bin=0 with out_ready=1 → out_valid rises 4 cycles after acceptance; diff=3, bout=0; in_ready returns the following cycle.
- a=2, b=5, bin=0 → diff=5, bout=1. Also a=0, b=0, bin=1 → diff=7, bout=1. Also a=7, b=7, bin=1 → diff=7, bout=1.
- a=6, b=1, bin=1 with out_ready=0 for 10 cycles → out_valid stays high and diff=4, bout=0 stay constant; a single out_ready pulse completes the handshake; changes to in_valid/a/b during busy have no effect.
- Accept a=3, b=1, then drive rst_n=0 for one edge during SHIFT (cnt=1) → next cycle: in_ready=1, out_valid=0, busy=0, diff=0, bout=0; out_valid never rises for the aborted operation.
- Exhaustive WIDTH=3 sweep of all 128 (a, b, bin) combinations with random out_ready stalls → every result matches the reference model (a − b − bin) mod 8 and its borrow; the count of results equals the count of accepted operands.
- Re-run the sweep with WIDTH=1 and WIDTH=8 (random subset for 8) → latency is WIDTH+1 and all results are correct.
